ball_motion_engine: RTL and testbench

- Parametrised successor to the four-direction Pong ball FSM.
- Moves one square ball across a configurable playfield, one step per frame tick.
- Handles serve delay, wall bounces, paddle bounces, misses with score pulses, and speed-up on paddle hits.
- Sits between the paddle/collision logic and the pixel mux; answers per-pixel draw queries with a registered rgb.

---
 rtl/ball_motion_engine.sv | 194 +++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
// Square-ball motion engine for a Pong-style playfield.
// Steps the ball once per frame tick, bounces it off the top/bottom walls and
// paddles, speeds up every few paddle hits, reports misses as score pulses,
// and answers per-pixel draw queries with a registered colour.
module ball_motion_engine #(
  parameter int          SCREEN_X         = 640,
  parameter int          SCREEN_Y         = 480,
  parameter int          POS_W            = 10,
  parameter int          BALL_SIZE        = 8,
  parameter int          BASE_STEP        = 1,
  parameter int          MAX_STEP         = 4,
  parameter int          HITS_PER_SPEEDUP = 4,
  parameter int          SERVE_DELAY      = 60,
  parameter logic [2:0]  BALL_RGB         = 3'b111
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             frame_tick_i,
  input  logic             serve_i,
  input  logic             paddle_hit_i,
  input  logic [POS_W-1:0] row_i,
  input  logic [POS_W-1:0] col_i,
  output logic [2:0]       rgb_o,
  output logic [POS_W-1:0] pos_x_o,
  output logic [POS_W-1:0] pos_y_o,
  output logic             dir_x_o,
  output logic             dir_y_o,
  output logic [2:0]       step_o,
  output logic             score_left_o,
  output logic             score_right_o,
  output logic             moving_o
);

  localparam int HC_W = (HITS_PER_SPEEDUP < 1) ? 1 : $clog2(HITS_PER_SPEEDUP + 1);
  localparam int SC_W = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);

  // Everything positional is compared one bit wider so sums never wrap.
  localparam logic [POS_W:0]   XMAX = (POS_W+1)'(SCREEN_X - BALL_SIZE);
  localparam logic [POS_W:0]   YMAX = (POS_W+1)'(SCREEN_Y - BALL_SIZE);
  localparam logic [POS_W:0]   BSZ  = (POS_W+1)'(BALL_SIZE);
  localparam logic [POS_W-1:0] X0   = POS_W'((SCREEN_X - BALL_SIZE) / 2);
  localparam logic [POS_W-1:0] Y0   = POS_W'((SCREEN_Y - BALL_SIZE) / 2);
  localparam logic [2:0]       STEP_BASE = 3'(BASE_STEP);
  localparam logic [2:0]       STEP_MAX  = 3'(MAX_STEP);
  localparam logic [HC_W-1:0]  HITS_TGT  = HC_W'(HITS_PER_SPEEDUP);
  localparam logic [SC_W-1:0]  SRV_TGT   = SC_W'(SERVE_DELAY);

  typedef enum logic [1:0] {IDLE, SERVE_WAIT, MOVING, SCORED} state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]       step_q, step_d;
  logic [HC_W-1:0]  hit_q, hit_d;
  logic [SC_W-1:0]  srv_q, srv_d;
  logic             sl_q, sl_d, sr_q, sr_d;
  logic [2:0]       rgb_q, rgb_d;

  logic [POS_W:0]   px, py, s, cx, ry;
  logic             scored;

  assign px = {1'b0, pos_x_q};
  assign py = {1'b0, pos_y_q};
  assign s  = (POS_W+1)'(step_q);
  assign cx = {1'b0, col_i};
  assign ry = {1'b0, row_i};

  // Next-state and motion: one step per frame tick while MOVING.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    step_d  = step_q;
    hit_d   = hit_q;
    srv_d   = srv_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    scored  = 1'b0;
    case (state_q)
      IDLE: begin
        pos_x_d = X0;
        pos_y_d = Y0;
        if (serve_i) begin
          state_d = SERVE_WAIT;
          srv_d   = '0;
          step_d  = STEP_BASE;
          hit_d   = '0;
        end
      end
      SERVE_WAIT: begin
        if (frame_tick_i) begin
          srv_d = srv_q + 1'b1;
          if (srv_q + 1'b1 == SRV_TGT) state_d = MOVING;
        end
      end
      MOVING: begin
        if (frame_tick_i) begin
          if (paddle_hit_i) begin
            dir_x_d = ~dir_x_q;
            hit_d   = hit_q + 1'b1;
            if (hit_q + 1'b1 == HITS_TGT) begin
              hit_d  = '0;
              step_d = (step_q >= STEP_MAX) ? STEP_MAX : step_q + 3'd1;
            end
            // Move away in the new direction; clamp so a late hit can never
            // push the ball outside the playfield.
            if (dir_x_q) pos_x_d = (px + s > XMAX) ? XMAX[POS_W-1:0] : pos_x_q + s[POS_W-1:0];
            else         pos_x_d = (px < s) ? '0 : pos_x_q - s[POS_W-1:0];
          end else if (dir_x_q && px < s) begin
            sr_d    = 1'b1;
            scored  = 1'b1;
            state_d = SCORED;
          end else if (!dir_x_q && px + s > XMAX) begin
            sl_d    = 1'b1;
            scored  = 1'b1;
            state_d = SCORED;
          end else begin
            pos_x_d = dir_x_q ? pos_x_q - s[POS_W-1:0] : pos_x_q + s[POS_W-1:0];
          end
          if (!scored) begin
            if (!dir_y_q) begin
              if (py + s >= YMAX) begin
                pos_y_d = YMAX[POS_W-1:0];
                dir_y_d = 1'b1;
              end else pos_y_d = pos_y_q + s[POS_W-1:0];
            end else begin
              if (py <= s) begin
                pos_y_d = '0;
                dir_y_d = 1'b0;
              end else pos_y_d = pos_y_q - s[POS_W-1:0];
            end
          end
        end
      end
      SCORED: begin
        // Re-serve from centre, heading toward the player who scored.
        pos_x_d = X0;
        pos_y_d = Y0;
        dir_x_d = ~dir_x_q;
        srv_d   = '0;
        state_d = SERVE_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel query against the current position; result lands next cycle.
  always_comb begin
    rgb_d = 3'b000;
    if (cx >= px && cx < px + BSZ && ry >= py && ry < py + BSZ) rgb_d = BALL_RGB;
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      pos_x_q <= X0;
      pos_y_q <= Y0;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      step_q  <= STEP_BASE;
      hit_q   <= '0;
      srv_q   <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
      rgb_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
      srv_q   <= srv_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb_o         = rgb_q;
  assign pos_x_o       = pos_x_q;
  assign pos_y_o       = pos_y_q;
  assign dir_x_o       = dir_x_q;
  assign dir_y_o       = dir_y_q;
  assign step_o        = step_q;
  assign score_left_o  = sl_q;
  assign score_right_o = sr_q;
  assign moving_o      = (state_q == MOVING);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Bench for ball_motion_engine: directed scenarios on a small playfield plus a
// randomized run checked against a plain-integer model of the ball's rules.
module tb_ball_motion_engine;

  localparam int SX = 64, SY = 48, PW = 10, BS = 4;
  localparam int BASE = 1, MAXS = 3, HPS = 2, SD = 2;
  localparam int XMAX = SX - BS, YMAX = SY - BS;
  localparam int X0 = (SX - BS) / 2, Y0 = (SY - BS) / 2;

  logic          clk, rst_n, ft, sv, ph;
  logic [PW-1:0] row, col;
  logic [2:0]    rgb, step;
  logic [PW-1:0] pos_x, pos_y;
  logic          dir_x, dir_y, sl, sr, moving;

  int n_vec, n_err;

  // model state: 0 idle, 1 waiting to serve, 2 in play, 3 just scored
  int m_state, m_x, m_y, m_dx, m_dy, m_step, m_hits, m_cnt, m_sl, m_sr, m_rgb;

  ball_motion_engine #(
    .SCREEN_X(SX), .SCREEN_Y(SY), .POS_W(PW), .BALL_SIZE(BS), .BASE_STEP(BASE),
    .MAX_STEP(MAXS), .HITS_PER_SPEEDUP(HPS), .SERVE_DELAY(SD), .BALL_RGB(3'b111)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n), .frame_tick_i(ft), .serve_i(sv),
    .paddle_hit_i(ph), .row_i(row), .col_i(col), .rgb_o(rgb),
    .pos_x_o(pos_x), .pos_y_o(pos_y), .dir_x_o(dir_x), .dir_y_o(dir_y),
    .step_o(step), .score_left_o(sl), .score_right_o(sr), .moving_o(moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_x = X0; m_y = Y0; m_dx = 0; m_dy = 0; m_step = BASE;
    m_hits = 0; m_cnt = 0; m_sl = 0; m_sr = 0; m_rgb = 0;
  endtask

  task automatic model_step(input int t, input int srv, input int hit, input int r, input int c);
    int s; int sc;
    m_rgb = (c >= m_x && c < m_x + BS && r >= m_y && r < m_y + BS) ? 7 : 0;
    m_sl = 0; m_sr = 0;
    case (m_state)
      0: if (srv != 0) begin m_state = 1; m_cnt = 0; m_step = BASE; m_hits = 0; end
      1: if (t != 0) begin m_cnt++; if (m_cnt == SD) m_state = 2; end
      2: if (t != 0) begin
        s = m_step; sc = 0;
        if (hit != 0) begin
          m_dx = 1 - m_dx; m_hits++;
          if (m_hits == HPS) begin m_hits = 0; m_step = (m_step + 1 > MAXS) ? MAXS : m_step + 1; end
          if (m_dx == 1) m_x = (m_x - s < 0) ? 0 : m_x - s;
          else           m_x = (m_x + s > XMAX) ? XMAX : m_x + s;
        end else if (m_dx == 1 && m_x < s) begin m_sr = 1; sc = 1; m_state = 3; end
        else if (m_dx == 0 && m_x + s > XMAX) begin m_sl = 1; sc = 1; m_state = 3; end
        else m_x = (m_dx == 1) ? m_x - s : m_x + s;
        if (sc == 0) begin
          if (m_dy == 0) begin
            if (m_y + s >= YMAX) begin m_y = YMAX; m_dy = 1; end else m_y = m_y + s;
          end else begin
            if (m_y <= s) begin m_y = 0; m_dy = 0; end else m_y = m_y - s;
          end
        end
      end
      default: begin m_x = X0; m_y = Y0; m_dx = 1 - m_dx; m_state = 1; m_cnt = 0; end
    endcase
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic apply(input bit t, input bit srv, input bit hit);
    ft = t; sv = srv; ph = hit;
    model_step(int'(t), int'(srv), int'(hit), int'(row), int'(col));
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    ft = 0; sv = 0; ph = 0; row = '0; col = '0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({pos_x, pos_y, dir_x, dir_y, step, sl, sr, moving, rgb} !==
        {10'd30, 10'd22, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset: got x=%0d y=%0d dx=%b dy=%b step=%0d sl=%b sr=%b mv=%b rgb=%0d", pos_x, pos_y, dir_x, dir_y, step, sl, sr, moving, rgb);
    end
  endtask

  task automatic test_serve();
    apply(1'b0, 1'b1, 1'b0);
    n_vec++; if (moving !== 1'b0) begin n_err++; $display("FAIL serve_wait: moving=%b want 0", moving); end
    ticks(1);
    n_vec++; if ({moving, pos_x, pos_y} !== {1'b0, 10'd30, 10'd22}) begin n_err++; $display("FAIL serve_tick1: mv=%b x=%0d y=%0d want 0,30,22", moving, pos_x, pos_y); end
    ticks(1);
    n_vec++; if ({moving, pos_x, pos_y} !== {1'b1, 10'd30, 10'd22}) begin n_err++; $display("FAIL serve_tick2: mv=%b x=%0d y=%0d want 1,30,22", moving, pos_x, pos_y); end
    ticks(1);
    n_vec++; if ({pos_x, pos_y} !== {10'd31, 10'd23}) begin n_err++; $display("FAIL first_move: x=%0d y=%0d want 31,23", pos_x, pos_y); end
  endtask

  task automatic test_wall_bounce();
    ticks(20);
    n_vec++; if ({pos_y, dir_y} !== {10'd43, 1'b0}) begin n_err++; $display("FAIL wall_pre: y=%0d dy=%b want 43,0", pos_y, dir_y); end
    ticks(1);
    n_vec++; if ({pos_y, dir_y} !== {10'd44, 1'b1}) begin n_err++; $display("FAIL wall_hit: y=%0d dy=%b want 44,1", pos_y, dir_y); end
    ticks(1);
    n_vec++; if ({pos_y, dir_y} !== {10'd43, 1'b1}) begin n_err++; $display("FAIL wall_after: y=%0d dy=%b want 43,1", pos_y, dir_y); end
  endtask

  task automatic test_score();
    ticks(7);
    n_vec++; if (pos_x !== 10'd60) begin n_err++; $display("FAIL right_edge: x=%0d want 60", pos_x); end
    ticks(1);
    n_vec++; if ({sl, sr, moving} !== 3'b100) begin n_err++; $display("FAIL score_left: sl=%b sr=%b mv=%b want 1,0,0", sl, sr, moving); end
    apply(1'b0, 1'b0, 1'b0);
    n_vec++; if ({sl, pos_x, pos_y, dir_x} !== {1'b0, 10'd30, 10'd22, 1'b1}) begin n_err++; $display("FAIL rescore_left: sl=%b x=%0d y=%0d dx=%b want 0,30,22,1", sl, pos_x, pos_y, dir_x); end
    ticks(2 + 30);
    n_vec++; if ({pos_x, dir_x} !== {10'd0, 1'b1}) begin n_err++; $display("FAIL left_edge: x=%0d dx=%b want 0,1", pos_x, dir_x); end
    ticks(1);
    n_vec++; if ({sl, sr} !== 2'b01) begin n_err++; $display("FAIL score_right: sl=%b sr=%b want 0,1", sl, sr); end
    apply(1'b0, 1'b0, 1'b0);
    n_vec++; if ({sr, pos_x, pos_y, dir_x, moving} !== {1'b0, 10'd30, 10'd22, 1'b0, 1'b0}) begin n_err++; $display("FAIL rescore_right: sr=%b x=%0d y=%0d dx=%b mv=%b want 0,30,22,0,0", sr, pos_x, pos_y, dir_x, moving); end
    apply(1'b0, 1'b1, 1'b0);
    ticks(1);
    n_vec++; if (moving !== 1'b0) begin n_err++; $display("FAIL serve_ignored: moving=%b want 0 after 1 tick", moving); end
    ticks(1);
    n_vec++; if (moving !== 1'b1) begin n_err++; $display("FAIL serve_resume: moving=%b want 1", moving); end
  endtask

  task automatic test_paddle();
    // From centre heading right: score on the right, re-serve left, reach x=0.
    ticks(31);
    apply(1'b0, 1'b0, 1'b0);
    ticks(2 + 30);
    n_vec++; if ({pos_x, dir_x, step} !== {10'd0, 1'b1, 3'd1}) begin n_err++; $display("FAIL paddle_pre: x=%0d dx=%b step=%0d want 0,1,1", pos_x, dir_x, step); end
    apply(1'b1, 1'b0, 1'b1);
    n_vec++; if ({sr, dir_x, pos_x, step} !== {1'b0, 1'b0, 10'd1, 3'd1}) begin n_err++; $display("FAIL paddle_hit1: sr=%b dx=%b x=%0d step=%0d want 0,0,1,1", sr, dir_x, pos_x, step); end
    apply(1'b1, 1'b0, 1'b1);
    n_vec++; if ({step, dir_x, pos_x} !== {3'd2, 1'b1, 10'd0}) begin n_err++; $display("FAIL paddle_speedup: step=%0d dx=%b x=%0d want 2,1,0", step, dir_x, pos_x); end
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b1);
    n_vec++; if ({step, dir_x, pos_x} !== {3'd3, 1'b1, 10'd0}) begin n_err++; $display("FAIL paddle_saturate: step=%0d dx=%b x=%0d want 3,1,0", step, dir_x, pos_x); end
  endtask

  task automatic test_pixel();
    do_reset();
    row = 10'd22; col = 10'd33; apply(1'b0, 1'b0, 1'b0);
    n_vec++; if (rgb !== 3'b111) begin n_err++; $display("FAIL pix_in: rgb=%b want 111", rgb); end
    col = 10'd34; apply(1'b0, 1'b0, 1'b0);
    n_vec++; if (rgb !== 3'b000) begin n_err++; $display("FAIL pix_right: rgb=%b want 000", rgb); end
    col = 10'd29; apply(1'b0, 1'b0, 1'b0);
    n_vec++; if (rgb !== 3'b000) begin n_err++; $display("FAIL pix_left: rgb=%b want 000", rgb); end
    row = 10'd26; col = 10'd30; apply(1'b0, 1'b0, 1'b0);
    n_vec++; if (rgb !== 3'b000) begin n_err++; $display("FAIL pix_below: rgb=%b want 000", rgb); end
    row = 10'd25; apply(1'b0, 1'b0, 1'b0);
    n_vec++; if (rgb !== 3'b111) begin n_err++; $display("FAIL pix_corner: rgb=%b want 111", rgb); end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(1'b0, 1'b1, 1'b0);
    ticks(6);
    row = 10'd24; col = 10'd34; apply(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({pos_x, pos_y, dir_x, dir_y, step, sl, sr, moving, rgb} !==
        {10'd30, 10'd22, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL async_reset: got x=%0d y=%0d dx=%b dy=%b step=%0d mv=%b rgb=%0d", pos_x, pos_y, dir_x, dir_y, step, moving, rgb);
    end
    ft = 0; sv = 0; ph = 0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int r, c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = m_y + int'($urandom_range(0, 7)) - 2; if (r < 0) r = 0;
      c = m_x + int'($urandom_range(0, 7)) - 2; if (c < 0) c = 0;
      if ($urandom_range(0, 3) == 0) begin r = int'($urandom_range(0, SY - 1)); c = int'($urandom_range(0, SX - 1)); end
      row = PW'(r); col = PW'(c);
      apply($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      n_vec++;
      if ({pos_x, pos_y, dir_x, dir_y, step, sl, sr, moving, rgb} !==
          {PW'(m_x), PW'(m_y), m_dx[0], m_dy[0], 3'(m_step), m_sl[0], m_sr[0], (m_state == 2), 3'(m_rgb)}) begin
        n_err++;
        $display("FAIL random[%0d]: got x=%0d y=%0d dx=%b dy=%b st=%0d sl=%b sr=%b mv=%b rgb=%0d want x=%0d y=%0d dx=%0d dy=%0d st=%0d sl=%0d sr=%0d mv=%0d rgb=%0d",
                 i, pos_x, pos_y, dir_x, dir_y, step, sl, sr, moving, rgb,
                 m_x, m_y, m_dx, m_dy, m_step, m_sl, m_sr, (m_state == 2), m_rgb);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b1; ft = 0; sv = 0; ph = 0; row = '0; col = '0;
    model_reset();
    test_reset();
    test_serve();
    test_wall_bounce();
    test_score();
    test_paddle();
    test_pixel();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
